vproc_dispatcher: RTL

- Issue-stage scheduler of the vector core.
- Accepts one decoded instruction per cycle and applies vreg hazard checks (RAW, WAW, v0 mask read) against a 32-bit pending-write scoreboard.
- Routes the instruction by its op_unit code to LSU, ALU, MUL, SLD or ELEM over per-unit valid/ready links.
- Retires scoreboard entries when units report completion; each unit retires in order, so a per-unit FIFO of destination masks is kept.

---
 rtl/vproc_dispatcher.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/vproc_dispatcher.sv
// Vector issue-stage dispatcher: vreg hazard checks against a pending-write scoreboard,
// per-unit valid/ready routing, and in-order per-unit retire FIFOs of destination masks.
module vproc_dispatcher #(
   parameter int unsigned UNIT_CNT   = 5,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned ID_W       = 4
) (
   input  logic                clk_i,
   input  logic                async_rst_i,
   input  logic                instr_valid_i,
   output logic                instr_ready_o,
   input  logic [2:0]          instr_unit_i,
   input  logic [ID_W-1:0]     instr_id_i,
   input  logic [1:0]          instr_emul_i,
   input  logic                instr_rs1_vreg_i,
   input  logic                instr_rs2_vreg_i,
   input  logic [4:0]          instr_rs1_addr_i,
   input  logic [4:0]          instr_rs2_addr_i,
   input  logic                instr_masked_i,
   input  logic                instr_vd_vreg_i,
   input  logic [4:0]          instr_vd_addr_i,
   output logic [UNIT_CNT-1:0] disp_valid_o,
   input  logic [UNIT_CNT-1:0] disp_ready_i,
   output logic [ID_W-1:0]     disp_id_o,
   input  logic [UNIT_CNT-1:0] done_i,
   output logic                cfg_fire_o,
   output logic [31:0]         pending_o,
   output logic                idle_o,
   output logic                err_o
);

   localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   localparam logic [2:0]      UnitCfg = 3'd5;
   localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);
   localparam logic [PtrW-1:0] PtrLast = PtrW'(FIFO_DEPTH - 1);
   localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);

   // Register group covered by a base register; unaligned bases round down to the group.
   function automatic logic [31:0] grp_mask(input logic [4:0] addr, input logic [1:0] emul);
      logic [31:0] ones;
      logic [4:0]  base;
      unique case (emul)
         2'd0:    ones = 32'h0000_0001;
         2'd1:    ones = 32'h0000_0003;
         2'd2:    ones = 32'h0000_000F;
         default: ones = 32'h0000_00FF;
      endcase
      base = addr & ~((5'd1 << emul) - 5'd1);
      return ones << base;
   endfunction

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
      return (ptr == PtrLast) ? '0 : ptr + PtrOne;
   endfunction

   logic [31:0]         pending_q, pending_d;
   logic                err_q, err_d;
   logic [31:0]         fifo_q   [UNIT_CNT][FIFO_DEPTH];
   logic [31:0]         fifo_d   [UNIT_CNT][FIFO_DEPTH];
   logic [PtrW-1:0]     wr_ptr_q [UNIT_CNT];
   logic [PtrW-1:0]     wr_ptr_d [UNIT_CNT];
   logic [PtrW-1:0]     rd_ptr_q [UNIT_CNT];
   logic [PtrW-1:0]     rd_ptr_d [UNIT_CNT];
   logic [CntW-1:0]     cnt_q    [UNIT_CNT];
   logic [CntW-1:0]     cnt_d    [UNIT_CNT];

   logic [31:0]         rd_mask, wr_mask, clr_mask;
   logic                hazard, idle;
   logic [UNIT_CNT-1:0] unit_sel, full, empty, fire, pop;

   // Hazard detection uses registered pending only; a same-cycle retire does not unblock.
   always_comb begin
      rd_mask = '0;
      if (instr_rs1_vreg_i) rd_mask = rd_mask | grp_mask(instr_rs1_addr_i, instr_emul_i);
      if (instr_rs2_vreg_i) rd_mask = rd_mask | grp_mask(instr_rs2_addr_i, instr_emul_i);
      if (instr_masked_i)   rd_mask = rd_mask | 32'h0000_0001;
      wr_mask = instr_vd_vreg_i ? grp_mask(instr_vd_addr_i, instr_emul_i) : '0;
      hazard  = |((rd_mask | wr_mask) & pending_q);
   end

   always_comb begin
      unit_sel = '0;
      full     = '0;
      empty    = '0;
      for (int u = 0; u < int'(UNIT_CNT); u++) begin
         unit_sel[u] = (instr_unit_i == 3'(u));
         full[u]     = (cnt_q[u] == CntFull);
         empty[u]    = (cnt_q[u] == '0);
      end
      idle = &empty;
   end

   always_comb begin
      disp_valid_o  = unit_sel & ~full & {UNIT_CNT{instr_valid_i & ~hazard}};
      fire          = disp_valid_o & disp_ready_i;
      // Config changes wait for a fully drained machine.
      cfg_fire_o    = instr_valid_i & (instr_unit_i == UnitCfg) & idle & (pending_q == '0);
      instr_ready_o = (|fire) | cfg_fire_o;
      disp_id_o     = instr_id_i;
      pop           = done_i & ~empty;
      err_d         = err_q | (|(done_i & empty));
   end

   always_comb begin
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      clr_mask = '0;
      for (int u = 0; u < int'(UNIT_CNT); u++) begin
         if (pop[u]) begin
            clr_mask    = clr_mask | fifo_q[u][rd_ptr_q[u]];
            rd_ptr_d[u] = ptr_inc(rd_ptr_q[u]);
         end
         // Empty write masks are pushed too so that retire order stays aligned.
         if (fire[u]) begin
            fifo_d[u][wr_ptr_q[u]] = wr_mask;
            wr_ptr_d[u]            = ptr_inc(wr_ptr_q[u]);
         end
         unique case ({fire[u], pop[u]})
            2'b10:   cnt_d[u] = cnt_q[u] + CntOne;
            2'b01:   cnt_d[u] = cnt_q[u] - CntOne;
            default: cnt_d[u] = cnt_q[u];
         endcase
      end
      pending_d = (pending_q & ~clr_mask) | ((|fire) ? wr_mask : '0);
   end

   always_ff @(posedge clk_i or posedge async_rst_i) begin
      if (async_rst_i) begin
         pending_q <= '0;
         err_q     <= 1'b0;
         for (int u = 0; u < int'(UNIT_CNT); u++) begin
            wr_ptr_q[u] <= '0;
            rd_ptr_q[u] <= '0;
            cnt_q[u]    <= '0;
            for (int d = 0; d < int'(FIFO_DEPTH); d++) begin
               fifo_q[u][d] <= '0;
            end
         end
      end else begin
         pending_q <= pending_d;
         err_q     <= err_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         fifo_q    <= fifo_d;
      end
   end

   assign pending_o = pending_q;
   assign idle_o    = idle;
   assign err_o     = err_q;

endmodule
